// File: rtl/ks10_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : ks10_bus_arb
// Purpose  : Backplane bus arbiter that sits directly downstream of the KS10
//            CPU. Three bus masters (console, UBA, CPU) share one memory/IO
//            bus. One master at a time is granted and its request, address
//            and write data are driven onto the bus. The slave acknowledge is
//            returned only to the granted master. Read data from the slaves
//            is broadcast to every master.
//
//            Arbitration is fixed priority (console > UBA > CPU) and is only
//            performed in IDLE. A grant is never preempted. A grant ends when
//            the owner drops its request, or when it has been held for
//            HOLDMAX cycles, in which case arbERR pulses for one cycle. Every
//            grant is followed by one dead RELEASE cycle, which gives the bus
//            an address/flag turnaround between masters.
//
// Parameters:
//   HOLDMAX    maximum GRANT cycles before a forced release (>= 4)
//
// Ports:
//   clk        in   1    clock
//   rst        in   1    asynchronous, active-high reset
//   cslREQI    in   1    console bus request
//   cslADDRI   in   36   console address+flags [0:35]
//   cslDATAI   in   36   console write data [0:35]
//   cslACKO    out  1    console acknowledge
//   ubaREQI    in   1    UBA bus request
//   ubaADDRI   in   36   UBA address+flags [0:35]
//   ubaDATAI   in   36   UBA write data [0:35]
//   ubaACKO    out  1    UBA acknowledge
//   cpuREQI    in   1    CPU bus request
//   cpuADDRI   in   36   CPU address+flags [0:35]
//   cpuDATAI   in   36   CPU write data [0:35]
//   cpuACKO    out  1    CPU acknowledge
//   busREQO    out  1    bus request to the slaves
//   busADDRO   out  36   bus address+flags
//   busDATAO   out  36   bus write data
//   busACKI    in   1    OR of the slave acknowledges
//   busDATAI   in   36   OR of the slave read data
//   mstDATAO   out  36   read data broadcast to all masters
//   arbGNT     out  3    registered one-hot grant {csl,uba,cpu}
//   arbERR     out  1    one-cycle pulse after a forced (HOLDMAX) release
//
// Revision : 1.0  initial release
// ============================================================================
module ks10_bus_arb #(
   parameter int HOLDMAX = 1023
) (
   input  logic        clk,
   input  logic        rst,
   // console master
   input  logic        cslREQI,
   input  logic [0:35] cslADDRI,
   input  logic [0:35] cslDATAI,
   output logic        cslACKO,
   // UBA master
   input  logic        ubaREQI,
   input  logic [0:35] ubaADDRI,
   input  logic [0:35] ubaDATAI,
   output logic        ubaACKO,
   // CPU master
   input  logic        cpuREQI,
   input  logic [0:35] cpuADDRI,
   input  logic [0:35] cpuDATAI,
   output logic        cpuACKO,
   // shared bus
   output logic        busREQO,
   output logic [0:35] busADDRO,
   output logic [0:35] busDATAO,
   input  logic        busACKI,
   input  logic [0:35] busDATAI,
   // broadcast read data and arbiter status
   output logic [0:35] mstDATAO,
   output logic [2:0]  arbGNT,
   output logic        arbERR
);

   // Hold counter just wide enough to reach HOLDMAX-1; it never wraps.
   localparam int                CNT_W   = $clog2(HOLDMAX);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HOLDMAX - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        gnt_q,   gnt_d;     // {csl,uba,cpu}
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              err_q,   err_d;

   logic [2:0]        req_vec;            // {csl,uba,cpu}
   logic [2:0]        winner;
   logic              owner_req;
   logic              in_grant;

   assign req_vec   = {cslREQI, ubaREQI, cpuREQI};
   assign in_grant  = (state_q == ST_GRANT);
   // Request level of whoever currently owns the bus (zero if nobody does).
   assign owner_req = |(gnt_q & req_vec);

   // Fixed-priority pick, only consumed in IDLE.
   always_comb begin
      winner = 3'b000;
      if (cslREQI) begin
         winner = 3'b100;
      end else if (ubaREQI) begin
         winner = 3'b010;
      end else if (cpuREQI) begin
         winner = 3'b001;
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 3'b000;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            gnt_d = 3'b000;
            if (|req_vec) begin
               gnt_d   = winner;
               cnt_d   = '0;
               state_d = ST_GRANT;
            end
         end

         ST_GRANT: begin
            if (!owner_req) begin
               // Normal end of transfer (includes master-side NXM/NXD timeouts).
               state_d = ST_RELEASE;
               gnt_d   = 3'b000;
            end else if (cnt_q == CNT_MAX) begin
               // Owner has held the bus for HOLDMAX cycles: take it away.
               // The counter is left saturated; IDLE clears it on next grant.
               state_d = ST_RELEASE;
               gnt_d   = 3'b000;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_RELEASE: begin
            state_d = ST_IDLE;
            gnt_d   = 3'b000;
         end

         default: begin
            state_d = ST_IDLE;
            gnt_d   = 3'b000;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Bus-side outputs
   // ------------------------------------------------------------------
   // The request is passed through live so a master dropping REQ is seen by
   // the slaves in the same cycle, before the arbiter samples it.
   assign busREQO  = in_grant & owner_req;

   // AND-OR mux on the one-hot grant; all-zero whenever nobody is granted.
   assign busADDRO = ({36{in_grant & gnt_q[2]}} & cslADDRI)
                   | ({36{in_grant & gnt_q[1]}} & ubaADDRI)
                   | ({36{in_grant & gnt_q[0]}} & cpuADDRI);

   assign busDATAO = ({36{in_grant & gnt_q[2]}} & cslDATAI)
                   | ({36{in_grant & gnt_q[1]}} & ubaDATAI)
                   | ({36{in_grant & gnt_q[0]}} & cpuDATAI);

   // ------------------------------------------------------------------
   // Master-side outputs
   // ------------------------------------------------------------------
   // Acknowledge is routed with zero latency and only while a grant is
   // live; a stray busACKI in IDLE/RELEASE is dropped.
   assign cslACKO  = busACKI & gnt_q[2] & in_grant;
   assign ubaACKO  = busACKI & gnt_q[1] & in_grant;
   assign cpuACKO  = busACKI & gnt_q[0] & in_grant;

   assign mstDATAO = busDATAI;

   assign arbGNT   = gnt_q;
   assign arbERR   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ks10_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ks10_bus_arb
// Purpose  : Self-checking bench for ks10_bus_arb (HOLDMAX = 8). Cycle
//            vector table, hand-written multi-cycle sequences, and a
//            randomized run compared with a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ks10_bus_arb;

   localparam int HOLD = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cslREQI, ubaREQI, cpuREQI, busACKI;
   logic [0:35] cslADDRI, cslDATAI, ubaADDRI, ubaDATAI, cpuADDRI, cpuDATAI;
   logic [0:35] busDATAI;
   logic        cslACKO, ubaACKO, cpuACKO, busREQO, arbERR;
   logic [0:35] busADDRO, busDATAO, mstDATAO;
   logic [2:0]  arbGNT;

   int n_tests = 0;
   int n_fail  = 0;

   ks10_bus_arb #(.HOLDMAX(HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .cslREQI  (cslREQI),
      .cslADDRI (cslADDRI),
      .cslDATAI (cslDATAI),
      .cslACKO  (cslACKO),
      .ubaREQI  (ubaREQI),
      .ubaADDRI (ubaADDRI),
      .ubaDATAI (ubaDATAI),
      .ubaACKO  (ubaACKO),
      .cpuREQI  (cpuREQI),
      .cpuADDRI (cpuADDRI),
      .cpuDATAI (cpuDATAI),
      .cpuACKO  (cpuACKO),
      .busREQO  (busREQO),
      .busADDRO (busADDRO),
      .busDATAO (busDATAO),
      .busACKI  (busACKI),
      .busDATAI (busDATAI),
      .mstDATAO (mstDATAO),
      .arbGNT   (arbGNT),
      .arbERR   (arbERR)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [2:0] acks();
      return {cslACKO, ubaACKO, cpuACKO};
   endfunction

   // Cycle vector: inputs applied for one cycle, outputs expected during it.
   typedef struct {
      logic [2:0] req;     // {csl,uba,cpu}
      logic       ack;
      logic [2:0] gnt;
      logic       breq;
      logic [2:0] acko;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [2:0] r, input logic a, input logic [2:0] g,
                      input logic b, input logic [2:0] k);
      vec_t v;
      v.req = r; v.ack = a; v.gnt = g; v.breq = b; v.acko = k;
      vq.push_back(v);
   endtask

   // ---------------- reference model (transaction level) ----------------
   // Master index 0=csl,1=uba,2=cpu, which is also priority order.
   int          m_owner;   // -1 when the bus is free
   int          m_held;    // completed GRANT cycles of the current owner
   bit          m_dead;    // a turnaround cycle is pending
   bit          m_err;

   task automatic model_reset();
      m_owner = -1; m_held = 0; m_dead = 0; m_err = 0;
   endtask

   task automatic model_step(input logic [2:0] req3);
      bit r [3];
      bit e;
      r[0] = req3[2]; r[1] = req3[1]; r[2] = req3[0];
      e = 0;
      if (m_owner >= 0) begin
         m_held++;
         if (!r[m_owner]) begin
            m_owner = -1; m_dead = 1;
         end else if (m_held == HOLD) begin
            m_owner = -1; m_dead = 1; e = 1;
         end
      end else if (m_dead) begin
         m_dead = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (r[i]) begin
               m_owner = i; m_held = 0;
               break;
            end
         end
      end
      m_err = e;
   endtask

   initial begin
      logic [0:35] a_exp, d_exp;
      logic [2:0]  g_exp;
      logic [63:0] rnd;
      int gcyc, errs, ackcnt;
      bit seen;

      rst = 1'b1;
      {cslREQI, ubaREQI, cpuREQI, busACKI} = 4'b0000;
      cslADDRI = 36'o111111_111111; cslDATAI = 36'o444444_444444;
      ubaADDRI = 36'o222222_222222; ubaDATAI = 36'o555555_555555;
      cpuADDRI = 36'o333333_333333; cpuDATAI = 36'o666666_666666;
      busDATAI = '0;

      // ---------------- reset state ----------------
      #6;
      check("rst_gnt",  64'(arbGNT),   64'd0);
      check("rst_breq", 64'(busREQO),  64'd0);
      check("rst_addr", 64'(busADDRO), 64'd0);
      check("rst_data", 64'(busDATAO), 64'd0);
      check("rst_ack",  64'(acks()),   64'd0);
      check("rst_err",  64'(arbERR),   64'd0);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- vector table ----------------
      //   req    ack   gnt    breq  acko
      add(3'b000, 1'b0, 3'b000, 1'b0, 3'b000);  // idle
      add(3'b111, 1'b1, 3'b000, 1'b0, 3'b000);  // all request, ack dropped in IDLE
      add(3'b111, 1'b0, 3'b100, 1'b1, 3'b000);  // csl wins
      add(3'b111, 1'b1, 3'b100, 1'b1, 3'b100);
      add(3'b011, 1'b1, 3'b100, 1'b0, 3'b100);  // csl drops with ack: still delivered
      add(3'b011, 1'b1, 3'b000, 1'b0, 3'b000);  // release
      add(3'b011, 1'b0, 3'b000, 1'b0, 3'b000);  // idle
      add(3'b011, 1'b1, 3'b010, 1'b1, 3'b010);  // uba
      add(3'b001, 1'b0, 3'b010, 1'b0, 3'b000);
      add(3'b001, 1'b0, 3'b000, 1'b0, 3'b000);
      add(3'b001, 1'b0, 3'b000, 1'b0, 3'b000);
      add(3'b001, 1'b0, 3'b001, 1'b1, 3'b000);  // cpu
      add(3'b101, 1'b1, 3'b001, 1'b1, 3'b001);  // csl rises: no preemption
      add(3'b101, 1'b0, 3'b001, 1'b1, 3'b000);
      add(3'b100, 1'b0, 3'b001, 1'b0, 3'b000);  // cpu drops
      add(3'b100, 1'b0, 3'b000, 1'b0, 3'b000);  // release
      add(3'b100, 1'b0, 3'b000, 1'b0, 3'b000);  // idle
      add(3'b100, 1'b0, 3'b100, 1'b1, 3'b000);  // csl finally granted
      add(3'b000, 1'b1, 3'b100, 1'b0, 3'b100);
      add(3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
      add(3'b010, 1'b1, 3'b000, 1'b0, 3'b000);
      add(3'b010, 1'b0, 3'b010, 1'b1, 3'b000);
      add(3'b000, 1'b0, 3'b010, 1'b0, 3'b000);
      add(3'b000, 1'b0, 3'b000, 1'b0, 3'b000);

      foreach (vq[i]) begin
         tick();
         {cslREQI, ubaREQI, cpuREQI} = vq[i].req;
         busACKI = vq[i].ack;
         #1;
         a_exp = '0; d_exp = '0;
         if (vq[i].gnt[2]) begin a_exp = cslADDRI; d_exp = cslDATAI; end
         if (vq[i].gnt[1]) begin a_exp = ubaADDRI; d_exp = ubaDATAI; end
         if (vq[i].gnt[0]) begin a_exp = cpuADDRI; d_exp = cpuDATAI; end
         check($sformatf("vec%0d_gnt", i),  64'(arbGNT),   64'(vq[i].gnt));
         check($sformatf("vec%0d_breq", i), 64'(busREQO),  64'(vq[i].breq));
         check($sformatf("vec%0d_ack", i),  64'(acks()),   64'(vq[i].acko));
         check($sformatf("vec%0d_addr", i), 64'(busADDRO), 64'(a_exp));
         check($sformatf("vec%0d_data", i), 64'(busDATAO), 64'(d_exp));
         check($sformatf("vec%0d_err", i),  64'(arbERR),   64'd0);
      end

      // ---------------- ack in IDLE, read-data broadcast ----------------
      tick();
      {cslREQI, ubaREQI, cpuREQI} = 3'b000;
      busACKI  = 1'b1;
      busDATAI = 36'o777777_000000;
      #1;
      check("idle_ack",  64'(acks()),   64'd0);
      check("idle_mst",  64'(mstDATAO), 64'(36'o777777_000000));

      // ---------------- single CPU transfer ----------------
      tick();
      busACKI  = 1'b0;
      cpuADDRI = 36'o000100_001234;
      cpuREQI  = 1'b1;
      #1 check("cpu_idle_gnt", 64'(arbGNT), 64'd0);
      tick(); #1;
      check("cpu_gnt",  64'(arbGNT),   64'(3'b001));
      check("cpu_breq", 64'(busREQO),  64'd1);
      check("cpu_addr", 64'(busADDRO), 64'(36'o000100_001234));
      check("cpu_ack0", 64'(cpuACKO),  64'd0);
      tick(); #1 check("cpu_ack1", 64'(cpuACKO), 64'd0);
      tick(); #1 check("cpu_ack2", 64'(cpuACKO), 64'd0);
      tick(); busACKI = 1'b1;
      #1 check("cpu_ack_cycle", 64'(acks()), 64'(3'b001));
      tick(); busACKI = 1'b0; cpuREQI = 1'b0;
      #1;
      check("cpu_after_ack", 64'(cpuACKO), 64'd0);
      check("cpu_drop_breq", 64'(busREQO), 64'd0);
      tick(); #1 check("cpu_release", 64'(arbGNT), 64'd0);

      // ---------------- async reset during a CPU grant ----------------
      tick(); cpuREQI = 1'b1;
      tick(); #1 check("rstg_pre_gnt", 64'(arbGNT), 64'(3'b001));
      #2;
      rst = 1'b1; busACKI = 1'b1;
      #1;
      check("rstg_gnt",  64'(arbGNT),  64'd0);
      check("rstg_breq", 64'(busREQO), 64'd0);
      check("rstg_ack",  64'(acks()),  64'd0);
      tick(); rst = 1'b0; cpuREQI = 1'b0; busACKI = 1'b0;
      #1 check("rstg_idle0", 64'(arbGNT), 64'd0);
      tick(); #1 check("rstg_idle1", 64'(arbGNT), 64'd0);

      // ---------------- forced release after HOLD cycles ----------------
      tick(); ubaREQI = 1'b1; busACKI = 1'b0;
      gcyc = 0; errs = 0; ackcnt = 0; seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick(); #1;
         if (ubaACKO) ackcnt++;
         if (arbERR)  errs++;
         if (arbGNT == 3'b010) gcyc++;
         else if (gcyc > 0) begin
            seen = 1;
            check("force_err_pulse", 64'(arbERR), 64'd1);
            break;
         end
      end
      check("force_released", 64'(seen), 64'd1);
      check("force_gcycles",  64'(gcyc), 64'(HOLD));
      tick(); ubaREQI = 1'b0;
      #1;
      if (arbERR) errs++;
      check("force_err_count", 64'(errs),   64'd1);
      check("force_no_ack",    64'(ackcnt), 64'd0);
      check("force_idle_gnt",  64'(arbGNT), 64'd0);

      // ---------------- randomized run against the model ----------------
      tick(); rst = 1'b1;
      {cslREQI, ubaREQI, cpuREQI, busACKI} = 4'b0000;
      tick(); rst = 1'b0;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [2:0]  rq;
         logic [0:35] ma [3];
         logic [0:35] md [3];
         tick();
         if ($urandom_range(5) == 0) cslREQI = ~cslREQI;
         if ($urandom_range(5) == 0) ubaREQI = ~ubaREQI;
         if ($urandom_range(5) == 0) cpuREQI = ~cpuREQI;
         busACKI = ($urandom_range(2) == 0);
         rnd = {$urandom, $urandom}; cslADDRI = rnd[35:0];
         rnd = {$urandom, $urandom}; cslDATAI = rnd[35:0];
         rnd = {$urandom, $urandom}; ubaADDRI = rnd[35:0];
         rnd = {$urandom, $urandom}; ubaDATAI = rnd[35:0];
         rnd = {$urandom, $urandom}; cpuADDRI = rnd[35:0];
         rnd = {$urandom, $urandom}; cpuDATAI = rnd[35:0];
         rnd = {$urandom, $urandom}; busDATAI = rnd[35:0];
         #1;
         rq = {cslREQI, ubaREQI, cpuREQI};
         ma[0] = cslADDRI; ma[1] = ubaADDRI; ma[2] = cpuADDRI;
         md[0] = cslDATAI; md[1] = ubaDATAI; md[2] = cpuDATAI;
         g_exp = (m_owner < 0) ? 3'b000 : (3'b100 >> m_owner);
         check("rnd_gnt",  64'(arbGNT),  64'(g_exp));
         check("rnd_breq", 64'(busREQO), 64'((m_owner >= 0) && rq[2 - m_owner]));
         check("rnd_ack",  64'(acks()),  64'(busACKI ? g_exp : 3'b000));
         check("rnd_addr", 64'(busADDRO), 64'((m_owner >= 0) ? ma[m_owner] : 36'd0));
         check("rnd_data", 64'(busDATAO), 64'((m_owner >= 0) ? md[m_owner] : 36'd0));
         check("rnd_err",  64'(arbERR),  64'(m_err));
         check("rnd_mst",  64'(mstDATAO), 64'(busDATAI));
         model_step(rq);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
